// File: rtl/framebuffer_scissor_cmd_engine.sv
// Framebuffer command engine: scissored memset and streaming commit
// over a multi-pixel-per-beat RAM port with an AXIS/descriptor DMA path.
module framebuffer_scissor_cmd_engine #(
  parameter int NUMBER_OF_PIXELS_PER_BEAT = 4,
  parameter int NUMBER_OF_SUB_PIXELS = 4,
  parameter int SUB_PIXEL_WIDTH = 8,
  parameter int X_BIT_WIDTH = 11,
  parameter int Y_BIT_WIDTH = 11,
  parameter int FRAMEBUFFER_SIZE_IN_PIXEL_LG = 18,
  parameter int ADDR_WIDTH = 32,
  localparam int PPB = NUMBER_OF_PIXELS_PER_BEAT,
  localparam int PW = NUMBER_OF_SUB_PIXELS * SUB_PIXEL_WIDTH,
  localparam int MW = PPB * PW,
  localparam int MASKW = PPB * NUMBER_OF_SUB_PIXELS,
  localparam int LG = $clog2(PPB),
  localparam int MAW = FRAMEBUFFER_SIZE_IN_PIXEL_LG - LG
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PW-1:0]          confClearColor,
  input  logic                   confEnableScissor,
  input  logic [X_BIT_WIDTH-1:0] confScissorStartX,
  input  logic [X_BIT_WIDTH-1:0] confScissorEndX,
  input  logic [Y_BIT_WIDTH-1:0] confScissorStartY,
  input  logic [Y_BIT_WIDTH-1:0] confScissorEndY,
  input  logic [X_BIT_WIDTH-1:0] confXResolution,
  input  logic [Y_BIT_WIDTH-1:0] confYResolution,
  input  logic [NUMBER_OF_SUB_PIXELS-1:0] confMask,
  input  logic                   apply,
  output logic                   applied,
  input  logic                   cmdCommit,
  input  logic                   cmdMemset,
  input  logic [ADDR_WIDTH-1:0]  cmdAddr,
  output logic [MW-1:0]          writeDataPort,
  output logic                   writeEnablePort,
  output logic [MAW-1:0]         writeAddrPort,
  output logic [MASKW-1:0]       writeMaskPort,
  output logic [MAW-1:0]         readAddrPort,
  input  logic [MW-1:0]          readDataPort,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic [MW-1:0]          m_axis_tdata,
  output logic [MASKW-1:0]       m_axis_tstrb,
  output logic                   m_avalid,
  output logic [ADDR_WIDTH-1:0]  m_aaddr,
  output logic [ADDR_WIDTH-1:0]  m_abytes,
  input  logic                   m_aready
);

  localparam int NS = NUMBER_OF_SUB_PIXELS;
  localparam int XW = X_BIT_WIDTH;
  localparam int YW = Y_BIT_WIDTH;
  localparam int CW = XW - LG;
  localparam int TW = XW + YW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_MEMSET,
    S_CADDR,
    S_CSTREAM,
    S_CDRAIN
  } state_t;

  state_t state, state_n;

  logic [PW-1:0]         color;
  logic [NS-1:0]         cmask;
  logic [XW-1:0]         sx, ex, wpr;
  logic [YW-1:0]         sy, ey, y;
  logic                  do_commit;
  logic [ADDR_WIDTH-1:0] addr, abytes;
  logic [TW-1:0]         total, rd_addr;
  logic [CW-1:0]         col, c0, c1;
  logic [MAW-1:0]        row_base;
  logic                  row_end, last_row;

  logic [XW-1:0]         sx_n, ex_n, wpr_n;
  logic [YW-1:0]         sy_n, ey_n;
  logic                  empty_n;
  logic [TW-1:0]         total_n;
  logic [XW-1:0]         px;

  logic [1:0]            cnt;
  logic                  rd_pend, pend_last;
  logic [MW-1:0]         d0, d1;
  logic                  l0, l1;
  logic                  pop, issue, last_rd;

  // Region of the incoming command, clipped to the screen
  always_comb begin
    sx_n = '0;
    ex_n = confXResolution;
    sy_n = '0;
    ey_n = confYResolution;
    if (confEnableScissor) begin
      sx_n = confScissorStartX;
      sy_n = confScissorStartY;
      ex_n = (confScissorEndX < confXResolution) ?
             confScissorEndX : confXResolution;
      ey_n = (confScissorEndY < confYResolution) ?
             confScissorEndY : confYResolution;
    end
    empty_n = (sx_n >= ex_n) || (sy_n >= ey_n);
    wpr_n = confXResolution >> LG;
    total_n = TW'(wpr_n) * TW'(confYResolution);
  end

  assign c0 = CW'(sx >> LG);
  assign c1 = CW'((ex - XW'(1)) >> LG);
  assign row_end = (col == c1);
  assign last_row = (y == ey - YW'(1));
  assign last_rd = (rd_addr == total - TW'(1));

  assign pop = m_axis_tvalid && m_axis_tready;
  assign issue = (state == S_CSTREAM) &&
                 ((cnt == 2'd0) ||
                  (cnt == 2'd1 && (!rd_pend || pop)));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next state and control strobes
  always_comb begin
    state_n = state;
    applied = 1'b0;
    writeEnablePort = 1'b0;
    m_avalid = 1'b0;
    case (state)
      S_IDLE: begin
        applied = 1'b1;
        if (apply) begin
          if (cmdMemset && !empty_n) state_n = S_SETUP;
          else if (cmdCommit)        state_n = S_CADDR;
          else                       state_n = S_CDRAIN;
        end
      end
      S_SETUP: begin
        if (y == sy) state_n = S_MEMSET;
      end
      S_MEMSET: begin
        writeEnablePort = 1'b1;
        if (row_end && last_row)
          state_n = do_commit ? S_CADDR : S_IDLE;
      end
      S_CADDR: begin
        m_avalid = 1'b1;
        if (m_aready)
          state_n = (total == '0) ? S_CDRAIN : S_CSTREAM;
      end
      S_CSTREAM: begin
        if (issue && last_rd) state_n = S_CDRAIN;
      end
      S_CDRAIN: begin
        if (cnt == 2'd0 && !rd_pend) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Command latch, row-base accumulation and memset walk
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      color     <= '0;
      cmask     <= '0;
      sx        <= '0;
      ex        <= '0;
      sy        <= '0;
      ey        <= '0;
      wpr       <= '0;
      y         <= '0;
      col       <= '0;
      row_base  <= '0;
      do_commit <= 1'b0;
      addr      <= '0;
      abytes    <= '0;
      total     <= '0;
      rd_addr   <= '0;
      rd_pend   <= 1'b0;
      pend_last <= 1'b0;
    end else begin
      rd_pend   <= issue;
      pend_last <= issue && last_rd;
      if (issue) rd_addr <= rd_addr + TW'(1);
      case (state)
        S_IDLE: begin
          if (apply) begin
            color     <= confClearColor;
            cmask     <= confMask;
            sx        <= sx_n;
            ex        <= ex_n;
            sy        <= sy_n;
            ey        <= ey_n;
            wpr       <= wpr_n;
            do_commit <= cmdCommit;
            addr      <= cmdAddr;
            total     <= total_n;
            abytes    <= ADDR_WIDTH'(total_n) *
                         ADDR_WIDTH'(MW / 8);
            y         <= '0;
            row_base  <= '0;
            rd_addr   <= '0;
          end
        end
        S_SETUP: begin
          if (y == sy) begin
            col <= c0;
          end else begin
            y        <= y + YW'(1);
            row_base <= row_base + MAW'(wpr);
          end
        end
        S_MEMSET: begin
          if (row_end) begin
            col      <= c0;
            y        <= y + YW'(1);
            row_base <= row_base + MAW'(wpr);
          end else begin
            col <= col + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Two-entry skid buffer absorbing the RAM read latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 2'd0;
      d0  <= '0;
      d1  <= '0;
      l0  <= 1'b0;
      l1  <= 1'b0;
    end else begin
      case ({rd_pend, pop})
        2'b01: begin
          d0  <= d1;
          l0  <= l1;
          cnt <= cnt - 2'd1;
        end
        2'b10: begin
          if (cnt == 2'd0) begin
            d0 <= readDataPort;
            l0 <= pend_last;
          end else begin
            d1 <= readDataPort;
            l1 <= pend_last;
          end
          cnt <= cnt + 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            d0 <= readDataPort;
            l0 <= pend_last;
          end else begin
            d0 <= d1;
            l0 <= l1;
            d1 <= readDataPort;
            l1 <= pend_last;
          end
        end
        default: ;
      endcase
    end
  end

  // Per-pixel scissor edge mask combined with the channel mask
  always_comb begin
    writeMaskPort = '0;
    px = '0;
    for (int p = 0; p < PPB; p++) begin
      px = (XW'(col) << LG) + XW'(p);
      for (int c = 0; c < NS; c++) begin
        writeMaskPort[p*NS+c] = (px >= sx) && (px < ex) && cmask[c];
      end
    end
  end

  assign writeDataPort = {PPB{color}};
  assign writeAddrPort = row_base + MAW'(col);
  assign readAddrPort  = MAW'(rd_addr);

  assign m_axis_tvalid = (cnt != 2'd0);
  assign m_axis_tdata  = d0;
  assign m_axis_tlast  = m_axis_tvalid && l0;
  assign m_axis_tstrb  = '1;

  assign m_aaddr  = addr;
  assign m_abytes = abytes;

endmodule

// File: tb/tb_framebuffer_scissor_cmd_engine.sv
// Directed bench for framebuffer_scissor_cmd_engine with a RAM model,
// AXIS sink and address-channel responder.
module tb_framebuffer_scissor_cmd_engine;

  localparam int MW = 128;
  localparam int MASKW = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [31:0]  confClearColor = '0;
  logic         confEnableScissor = 1'b0;
  logic [10:0]  confScissorStartX = '0;
  logic [10:0]  confScissorEndX = '0;
  logic [10:0]  confScissorStartY = '0;
  logic [10:0]  confScissorEndY = '0;
  logic [10:0]  confXResolution = 11'd8;
  logic [10:0]  confYResolution = 11'd2;
  logic [3:0]   confMask = 4'hF;
  logic         apply = 1'b0;
  logic         applied;
  logic         cmdCommit = 1'b0;
  logic         cmdMemset = 1'b0;
  logic [31:0]  cmdAddr = '0;
  logic [MW-1:0] writeDataPort;
  logic         writeEnablePort;
  logic [15:0]  writeAddrPort;
  logic [MASKW-1:0] writeMaskPort;
  logic [15:0]  readAddrPort;
  logic [MW-1:0] readDataPort;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b1;
  logic         m_axis_tlast;
  logic [MW-1:0] m_axis_tdata;
  logic [MASKW-1:0] m_axis_tstrb;
  logic         m_avalid;
  logic [31:0]  m_aaddr;
  logic [31:0]  m_abytes;
  logic         m_aready = 1'b0;

  always #5 clk = ~clk;

  framebuffer_scissor_cmd_engine dut (
    .clk(clk),
    .reset(reset),
    .confClearColor(confClearColor),
    .confEnableScissor(confEnableScissor),
    .confScissorStartX(confScissorStartX),
    .confScissorEndX(confScissorEndX),
    .confScissorStartY(confScissorStartY),
    .confScissorEndY(confScissorEndY),
    .confXResolution(confXResolution),
    .confYResolution(confYResolution),
    .confMask(confMask),
    .apply(apply),
    .applied(applied),
    .cmdCommit(cmdCommit),
    .cmdMemset(cmdMemset),
    .cmdAddr(cmdAddr),
    .writeDataPort(writeDataPort),
    .writeEnablePort(writeEnablePort),
    .writeAddrPort(writeAddrPort),
    .writeMaskPort(writeMaskPort),
    .readAddrPort(readAddrPort),
    .readDataPort(readDataPort),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tstrb(m_axis_tstrb),
    .m_avalid(m_avalid),
    .m_aaddr(m_aaddr),
    .m_abytes(m_abytes),
    .m_aready(m_aready)
  );

  logic [MW-1:0] mem [0:65535];
  logic [MW-1:0] rd_q = '0;
  assign readDataPort = rd_q;

  // RAM: one-cycle read latency, byte-masked write
  always @(posedge clk) begin
    logic [MW-1:0] w;
    rd_q <= mem[readAddrPort];
    if (writeEnablePort) begin
      w = mem[writeAddrPort];
      for (int b = 0; b < MASKW; b++)
        if (writeMaskPort[b]) w[b*8 +: 8] = writeDataPort[b*8 +: 8];
      mem[writeAddrPort] = w;
    end
  end

  logic [15:0]   wr_addr[$];
  logic [15:0]   wr_mask[$];
  logic [MW-1:0] bt_data[$];
  logic          bt_last[$];
  logic [15:0]   bt_strb[$];
  int            stab_err = 0;
  int            hs_cnt = 0;
  logic [31:0]   hs_aaddr = '0;
  logic [31:0]   hs_abytes = '0;
  logic          tr_rand = 1'b0;
  logic          hold = 1'b0;
  logic [MW-1:0] hold_d = '0;
  logic          hold_l = 1'b0;
  int            adly = 0;

  // Sink, responder and write logger, all sampled on the falling edge
  always @(negedge clk) begin
    if (reset) begin
      hold = 1'b0;
      m_aready = 1'b0;
      adly = 0;
    end else begin
      m_axis_tready = tr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (hold && (!m_axis_tvalid || m_axis_tdata !== hold_d ||
                   m_axis_tlast !== hold_l))
        stab_err++;
      hold = m_axis_tvalid && !m_axis_tready;
      hold_d = m_axis_tdata;
      hold_l = m_axis_tlast;
      if (m_axis_tvalid && m_axis_tready) begin
        bt_data.push_back(m_axis_tdata);
        bt_last.push_back(m_axis_tlast);
        bt_strb.push_back(m_axis_tstrb);
      end
      if (writeEnablePort) begin
        wr_addr.push_back(writeAddrPort);
        wr_mask.push_back(writeMaskPort);
      end
      if (m_avalid) begin
        if (adly >= 3) begin
          m_aready = 1'b1;
          hs_cnt++;
          hs_aaddr = m_aaddr;
          hs_abytes = m_abytes;
        end else begin
          adly++;
          m_aready = 1'b0;
        end
      end else begin
        adly = 0;
        m_aready = 1'b0;
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [MW-1:0] got,
                     input logic [MW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic set_conf(input logic [31:0] c, input logic s,
                          input int sxv, input int exv,
                          input int syv, input int eyv,
                          input int xr, input int yr,
                          input logic [3:0] m);
    confClearColor = c;
    confEnableScissor = s;
    confScissorStartX = 11'(sxv);
    confScissorEndX = 11'(exv);
    confScissorStartY = 11'(syv);
    confScissorEndY = 11'(eyv);
    confXResolution = 11'(xr);
    confYResolution = 11'(yr);
    confMask = m;
  endtask

  task automatic clear_logs();
    wr_addr.delete();
    wr_mask.delete();
    bt_data.delete();
    bt_last.delete();
    bt_strb.delete();
    hs_cnt = 0;
    stab_err = 0;
  endtask

  task automatic run(input logic ms, input logic cm,
                     input logic [31:0] a, output int low);
    @(negedge clk);
    cmdMemset = ms;
    cmdCommit = cm;
    cmdAddr = a;
    apply = 1'b1;
    @(negedge clk);
    apply = 1'b0;
    low = 0;
    while (!applied && low < 2000) begin
      low++;
      @(negedge clk);
    end
    chk("cmd_done", 128'(applied), 128'(1));
  endtask

  function automatic logic [MW-1:0] pat(input int i);
    logic [31:0] b;
    b = 32'h5A000000 | 32'(i * 4);
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  logic [MW-1:0] exp4 [4];
  int low;
  int k;
  int nw, nb;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    exp4[0] = {4{32'hAABBCCDD}};
    exp4[1] = {4{32'hAA66CC88}};
    exp4[2] = {32'h11223344, 32'h11223344, 32'h11223344, 32'hAABBCCDD};
    exp4[3] = {32'hAABBCCDD, 32'hAABBCCDD, 32'h11223344, 32'h11223344};

    repeat (3) @(negedge clk);
    chk("rst_applied", 128'(applied), 128'(1));
    chk("rst_tvalid", 128'(m_axis_tvalid), 128'(0));
    chk("rst_tlast", 128'(m_axis_tlast), 128'(0));
    chk("rst_avalid", 128'(m_avalid), 128'(0));
    chk("rst_we", 128'(writeEnablePort), 128'(0));
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // full-screen memset
    set_conf(32'hAABBCCDD, 1'b0, 0, 0, 0, 0, 8, 2, 4'hF);
    clear_logs();
    run(1'b1, 1'b0, 32'h0, low);
    chk("t1_low", 128'(low), 128'(5));
    chk("t1_nwr", 128'(wr_addr.size()), 128'(4));
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", 128'(wr_addr[i]), 128'(i));
      chk("t1_mask", 128'(wr_mask[i]), 128'(16'hFFFF));
    end

    // scissor x[1,6) y[1,2)
    set_conf(32'h11223344, 1'b1, 1, 6, 1, 2, 8, 2, 4'hF);
    clear_logs();
    run(1'b1, 1'b0, 32'h0, low);
    chk("t2_low", 128'(low), 128'(4));
    chk("t2_nwr", 128'(wr_addr.size()), 128'(2));
    chk("t2_addr0", 128'(wr_addr[0]), 128'(2));
    chk("t2_mask0", 128'(wr_mask[0]), 128'(16'hFFF0));
    chk("t2_addr1", 128'(wr_addr[1]), 128'(3));
    chk("t2_mask1", 128'(wr_mask[1]), 128'(16'h00FF));

    // channel mask on x[4,8) y[0,1)
    set_conf(32'h55667788, 1'b1, 4, 8, 0, 1, 8, 2, 4'h5);
    clear_logs();
    run(1'b1, 1'b0, 32'h0, low);
    chk("t2b_low", 128'(low), 128'(2));
    chk("t2b_nwr", 128'(wr_addr.size()), 128'(1));
    chk("t2b_addr", 128'(wr_addr[0]), 128'(1));
    chk("t2b_mask", 128'(wr_mask[0]), 128'(16'h5555));

    // empty scissor
    set_conf(32'h0, 1'b1, 5, 5, 0, 2, 8, 2, 4'hF);
    clear_logs();
    run(1'b1, 1'b0, 32'h0, low);
    chk("t3_low", 128'(low), 128'(1));
    chk("t3_nwr", 128'(wr_addr.size()), 128'(0));

    // commit 8x2 with delayed descriptor accept
    set_conf(32'h0, 1'b0, 0, 0, 0, 0, 8, 2, 4'hF);
    clear_logs();
    run(1'b0, 1'b1, 32'h1000, low);
    chk("t4_hs", 128'(hs_cnt), 128'(1));
    chk("t4_aaddr", 128'(hs_aaddr), 128'(32'h1000));
    chk("t4_abytes", 128'(hs_abytes), 128'(64));
    chk("t4_nbeats", 128'(bt_data.size()), 128'(4));
    for (int i = 0; i < 4; i++) begin
      chk("t4_data", bt_data[i], exp4[i]);
      chk("t4_last", 128'(bt_last[i]), 128'(i == 3));
      chk("t4_strb", 128'(bt_strb[i]), 128'(16'hFFFF));
    end

    // commit 16x4 with random backpressure
    for (int i = 0; i < 16; i++) mem[i] = pat(i);
    set_conf(32'h0, 1'b0, 0, 0, 0, 0, 16, 4, 4'hF);
    clear_logs();
    tr_rand = 1'b1;
    run(1'b0, 1'b1, 32'h2000, low);
    tr_rand = 1'b0;
    chk("t5_abytes", 128'(hs_abytes), 128'(256));
    chk("t5_nbeats", 128'(bt_data.size()), 128'(16));
    for (int i = 0; i < 16; i++) begin
      chk("t5_data", bt_data[i], pat(i));
      chk("t5_last", 128'(bt_last[i]), 128'(i == 15));
    end
    chk("t5_stable", 128'(stab_err), 128'(0));

    // memset+commit, then reset mid-stream
    set_conf(32'hCAFEF00D, 1'b0, 0, 0, 0, 0, 8, 2, 4'hF);
    clear_logs();
    @(negedge clk);
    cmdMemset = 1'b1;
    cmdCommit = 1'b1;
    cmdAddr = 32'h3000;
    apply = 1'b1;
    @(negedge clk);
    apply = 1'b0;
    k = 0;
    while (bt_data.size() < 2 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("t6_beats_seen", 128'(bt_data.size() >= 2), 128'(1));
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_tvalid", 128'(m_axis_tvalid), 128'(0));
    chk("t6_rst_applied", 128'(applied), 128'(1));
    chk("t6_nwr", 128'(wr_addr.size()), 128'(4));
    chk("t6_beat0", bt_data[0], {4{32'hCAFEF00D}});
    chk("t6_beat1", bt_data[1], {4{32'hCAFEF00D}});
    nw = wr_addr.size();
    nb = bt_data.size();
    cmdMemset = 1'b0;
    cmdCommit = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("t6_no_wr", 128'(wr_addr.size()), 128'(nw));
    chk("t6_no_beat", 128'(bt_data.size()), 128'(nb));
    chk("t6_idle", 128'(applied), 128'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
